// File: rtl/wm8731_i2c_target_if.sv
// ---------------------------------------------------------------------------
// wm8731_i2c_target_if
// Bus bundle for the WM8731 control-port I2C target model.
//   scl_in, sda_in   raw I2C pin levels seen by the target (sda_in is the
//                    resolved open-drain line)
//   sda_oe           1 = target pulls SDA low, 0 = released
//   wr_valid         one-cycle pulse per accepted write frame
//   wr_addr/wr_data  register address / 9-bit data of the last accepted frame
//   rd_addr/rd_data  combinational shadow register readback
//   busy             high from START until STOP
//   frame_count      accepted frames, wraps 255 -> 0
// master: the bus/system side; slave: the target itself.
// ---------------------------------------------------------------------------
interface wm8731_i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic [7:0] frame_count;

    modport master (
        output scl_in, sda_in, rd_addr,
        input  sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, frame_count
    );

    modport slave (
        input  scl_in, sda_in, rd_addr,
        output sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, frame_count
    );
endinterface

// File: rtl/wm8731_i2c_target.sv
// ---------------------------------------------------------------------------
// wm8731_i2c_target
// Write-only I2C target modelling the WM8731 control port. SCL/SDA are
// oversampled on the system clock (clk must be >= 16x SCL). Frames of the
// form {DEV_ADDR+W, reg[6:0]+data[8], data[7:0]} are ACKed and committed to
// a 16 x 9-bit shadow register file; writing RESET_REG clears the file.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    wm8731_i2c_target_if.slave (pins, write report, readback, status)
// ---------------------------------------------------------------------------
module wm8731_i2c_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 16,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic                  clk,
    input  logic                  reset,
    wm8731_i2c_target_if.slave    bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ACK_ADDR = 3'd2;
    localparam logic [2:0] ST_SUB      = 3'd3;
    localparam logic [2:0] ST_ACK_SUB  = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_ACK_DATA = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    localparam logic [6:0] REG_LIMIT = 7'(NUM_REGS);

    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det, commit;

    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [6:0] sub_addr;
    logic       sub_d8;
    logic       sda_oe_q;
    logic       busy_q;
    logic       wr_valid_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic [7:0] frame_count_q;
    logic [8:0] shadow [NUM_REGS];

    // Synchronizers idle high so that releasing reset on a quiet bus does
    // not look like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= bus.sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    assign sda_rise = sda_s2 & ~sda_d;
    assign sda_fall = ~sda_s2 & sda_d;

    // START/STOP need SCL stable high on both samples around the SDA edge.
    assign start_det = sda_fall & scl_s2 & scl_d;
    assign stop_det  = sda_rise & scl_s2 & scl_d;

    // The frame is committed at the SCL fall that closes the data ACK.
    assign commit = (state == ST_ACK_DATA) && scl_fall && !start_det && !stop_det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= 4'd0;
            shift_reg     <= 8'd0;
            sub_addr      <= 7'd0;
            sub_d8        <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= 7'd0;
            wr_data_q     <= 9'd0;
            frame_count_q <= 8'd0;
        end else begin
            wr_valid_q <= 1'b0;
            if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= 4'd0;
                shift_reg <= 8'd0;
                busy_q    <= 1'b1;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state    <= ST_IDLE;
                bit_cnt  <= 4'd0;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_SUB, ST_DATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            // Byte complete: decide ACK at this fall.
                            bit_cnt <= 4'd0;
                            if (state == ST_ADDR) begin
                                if (shift_reg == {DEV_ADDR, 1'b0}) begin
                                    state    <= ST_ACK_ADDR;
                                    sda_oe_q <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else if (state == ST_SUB) begin
                                sub_addr <= shift_reg[7:1];
                                sub_d8   <= shift_reg[0];
                                state    <= ST_ACK_SUB;
                                sda_oe_q <= 1'b1;
                            end else begin
                                state    <= ST_ACK_DATA;
                                sda_oe_q <= 1'b1;
                            end
                        end
                    end
                    ST_ACK_ADDR: begin
                        if (scl_fall) begin
                            sda_oe_q  <= 1'b0;
                            shift_reg <= 8'd0;
                            state     <= ST_SUB;
                        end
                    end
                    ST_ACK_SUB: begin
                        if (scl_fall) begin
                            sda_oe_q  <= 1'b0;
                            shift_reg <= 8'd0;
                            state     <= ST_DATA;
                        end
                    end
                    ST_ACK_DATA: begin
                        if (scl_fall) begin
                            sda_oe_q      <= 1'b0;
                            state         <= ST_IGNORE;
                            wr_valid_q    <= 1'b1;
                            wr_addr_q     <= sub_addr;
                            wr_data_q     <= {sub_d8, shift_reg};
                            frame_count_q <= frame_count_q + 8'd1;
                        end
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Shadow file: RESET_REG wipes everything, out-of-range addresses are
    // reported on wr_valid but leave the file untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 9'd0;
        end else if (commit) begin
            if (sub_addr == RESET_REG) begin
                for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 9'd0;
            end else if (sub_addr < REG_LIMIT) begin
                shadow[sub_addr[3:0]] <= {sub_d8, shift_reg};
            end
        end
    end

    assign bus.sda_oe      = sda_oe_q;
    assign bus.busy        = busy_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_count = frame_count_q;
    assign bus.rd_data     = shadow[bus.rd_addr];

endmodule

// File: tb/tb_wm8731_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_wm8731_i2c_target
// Directed I2C master stimulus for wm8731_i2c_target. Expected write reports
// are queued when a frame is issued and popped by a monitor on wr_valid.
// ---------------------------------------------------------------------------
module tb_wm8731_i2c_target;

    localparam int Q = 80;  // quarter SCL period in ns (SCL = 32 clk)

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic [3:0] rd_idx;

    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    logic [8:0] model [16];
    int   exp_fc;

    wm8731_i2c_target_if bus ();

    // Open-drain SDA: either side can pull the line low.
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_m & ~bus.sda_oe;
    assign bus.rd_addr = rd_idx;

    wm8731_i2c_target dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every wr_valid must match the oldest queued frame.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset && bus.wr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_wr_valid: got addr 0x%0h data 0x%0h expected none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check_output("wr_addr", bus.wr_addr, e.addr);
                check_output("wr_data", bus.wr_data, e.data);
            end
        end
    end

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input int exp_ack, input string name);
        int acked;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        acked = (bus.sda_in == 1'b0) ? 1 : 0;
        #Q;
        scl_m = 1'b0; #Q;
        check_output(name, acked, exp_ack);
    endtask

    // Three-byte body of a valid frame; queues the report and updates the model.
    task automatic send_frame_bytes(input logic [6:0] r, input logic [8:0] d);
        exp_q.push_back('{addr: r, data: d});
        if (r == 7'h0F) begin
            for (int i = 0; i < 16; i++) model[i] = 9'd0;
        end else if (r < 7'd16) begin
            model[r[3:0]] = d;
        end
        exp_fc = (exp_fc + 1) % 256;
        send_byte(8'h34, 1, "ack_dev");
        send_byte({r, d[8]}, 1, "ack_sub");
        send_byte(d[7:0], 1, "ack_data");
    endtask

    task automatic apply_stimulus(input logic [6:0] r, input logic [8:0] d);
        i2c_start();
        send_frame_bytes(r, d);
        i2c_stop();
        #(2*Q);
    endtask

    task automatic read_reg(input int idx, input int expected, input string name);
        rd_idx = 4'(idx);
        @(negedge clk);
        check_output(name, bus.rd_data, expected);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 9'd0;
        exp_fc = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [6:0] cfg_reg [9];
        logic [8:0] cfg_dat [9];
        cfg_reg = '{7'h0F, 7'h06, 7'h08, 7'h02, 7'h03, 7'h07, 7'h09, 7'h04, 7'h05};
        cfg_dat = '{9'h000, 9'h000, 9'h002, 9'h074, 9'h074, 9'h001, 9'h001, 9'h016, 9'h006};

        scl_m  = 1'b1;
        sda_m  = 1'b1;
        rd_idx = 4'd0;
        do_reset();

        // Reset values
        check_output("rst_sda_oe", bus.sda_oe, 0);
        check_output("rst_wr_valid", bus.wr_valid, 0);
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_frame_count", bus.frame_count, 0);
        check_output("rst_wr_addr", bus.wr_addr, 0);
        check_output("rst_wr_data", bus.wr_data, 0);
        read_reg(2, 0, "rst_shadow2");

        // Single frame: reg 0x02 <= 0x074
        apply_stimulus(7'h02, 9'h074);
        read_reg(2, 9'h074, "single_shadow2");
        check_output("single_fc", bus.frame_count, 1);
        check_output("single_busy", bus.busy, 0);

        // Codec configuration sequence from a clean state
        do_reset();
        for (int i = 0; i < 9; i++) apply_stimulus(cfg_reg[i], cfg_dat[i]);
        read_reg(8, 9'h002, "cfg_shadow8");
        read_reg(5, 9'h006, "cfg_shadow5");
        read_reg(4, 9'h016, "cfg_shadow4");
        check_output("cfg_fc", bus.frame_count, 9);
        for (int i = 0; i < 16; i++) read_reg(i, model[i], "cfg_model");

        // RESET_REG clears the whole file
        apply_stimulus(7'h04, 9'h016);
        read_reg(4, 9'h016, "pre_clear_shadow4");
        apply_stimulus(7'h0F, 9'h000);
        for (int i = 0; i < 16; i++) read_reg(i, 0, "cleared_shadow");

        // Wrong device address and read bit: NACK everything, no commit
        i2c_start();
        send_byte(8'h36, 0, "nack_addr36");
        send_byte(8'h04, 0, "nack_sub36");
        send_byte(8'h74, 0, "nack_data36");
        check_output("busy_ignore", bus.busy, 1);
        i2c_stop();
        #(2*Q);
        check_output("busy_after_stop", bus.busy, 0);
        i2c_start();
        send_byte(8'h35, 0, "nack_addr35");
        send_byte(8'h04, 0, "nack_sub35");
        i2c_stop();
        #(2*Q);
        check_output("nack_fc", bus.frame_count, exp_fc);

        // STOP after the sub-address byte discards the frame
        apply_stimulus(7'h02, 9'h074);
        i2c_start();
        send_byte(8'h34, 1, "abort_dev");
        send_byte(8'h04, 1, "abort_sub");
        i2c_stop();
        #(2*Q);
        read_reg(2, 9'h074, "abort_shadow2");
        check_output("abort_fc", bus.frame_count, exp_fc);

        // Repeated START in the middle of the data byte, then a full frame
        i2c_start();
        send_byte(8'h34, 1, "rs_dev");
        send_byte(8'h06, 1, "rs_sub");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_start();
        send_frame_bytes(7'h07, 9'h001);
        i2c_stop();
        #(2*Q);
        read_reg(7, 9'h001, "rs_shadow7");
        read_reg(3, model[3], "rs_shadow3");
        check_output("rs_fc", bus.frame_count, exp_fc);

        // Fourth byte after a complete frame is NACKed
        i2c_start();
        send_frame_bytes(7'h05, 9'h055);
        send_byte(8'h12, 0, "nack_4th");
        i2c_stop();
        #(2*Q);
        read_reg(5, 9'h055, "fourth_shadow5");
        check_output("fourth_fc", bus.frame_count, exp_fc);

        // Reset asserted while the sub-address ACK is being driven
        i2c_start();
        send_byte(8'h34, 1, "rstmid_dev");
        for (int i = 7; i >= 0; i--) send_bit(logic'((8'h04 >> i) & 1));
        #Q;
        check_output("rstmid_sda_oe_before", bus.sda_oe, 1);
        reset = 1'b1;
        #1;
        check_output("rstmid_sda_oe_async", bus.sda_oe, 0);
        @(negedge clk);
        check_output("rstmid_busy", bus.busy, 0);
        check_output("rstmid_fc", bus.frame_count, 0);
        check_output("rstmid_wr_addr", bus.wr_addr, 0);
        check_output("rstmid_wr_data", bus.wr_data, 0);
        read_reg(5, 0, "rstmid_shadow5");
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
        do_reset();

        // Recovery after reset
        apply_stimulus(7'h09, 9'h001);
        read_reg(9, 9'h001, "recover_shadow9");
        check_output("recover_fc", bus.frame_count, 1);

        #(4*Q);
        check_output("pending_frames", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wm8731_i2c_target.md
Name: wm8731_i2c_target

Overview:
- I2C write-only target (responder) that models the WM8731 control port.
- Runs on the system clock and oversamples the SCL/SDA pins. Decodes 3-byte write frames of the form {dev_addr+W, reg[6:0]+data[8], data[7:0]}, drives ACK and updates a 16 x 9-bit shadow register file.
- Serves as the on-chip/simulation counterpart of the codec configuration sequencer, and as a readback monitor for the configured codec state.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address to ACK.
- NUM_REGS, 16, shadow register count; reg index width 4.
- RESET_REG, 7'h0F, register address whose write clears the whole file.

Ports:
- clk  input  1  system clock; must be >= 16x SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw SCL pin level.
- sda_in  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- wr_valid  output  1  one-cycle pulse per accepted frame.
- wr_addr  output  7  register address of last accepted frame.
- wr_data  output  9  data of last accepted frame.
- rd_addr  input  4  shadow register read index.
- rd_data  output  9  combinational read of shadow[rd_addr].
- busy  output  1  high from START until STOP/idle.
- frame_count  output  8  accepted frames, wraps 255->0.

Behaviour:
- Reset: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, frame_count=0, all shadow registers 0, state IDLE. Sync flops reset to 1 (bus idle).
- Input path:
  - 2-flop synchronizers on scl_in/sda_in, plus one history flop.
  - Edges are detected 3 clk after the pin change.
  - SCL rise = sample, SCL fall = shift/drive point.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are recognised in every state and take priority over data sampling.
- START (including a repeated start): clear bit counter and shift register; go to ADDR; busy=1; any partial frame is discarded.
- STOP: go to IDLE, busy=0, sda_oe=0. A partial frame is discarded with no wr_valid.
- States: IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, DATA, ACK_DATA, IGNORE.
- Byte reception: 8 bits, MSB first, sampled on SCL rise. After the 8th rise the byte is complete; the ACK decision is made at the following SCL fall.
- ADDR:
  - If byte == {DEV_ADDR,1'b0}, go to ACK_ADDR.
  - Otherwise (wrong address or R/W=1), leave sda_oe=0 (NACK) and go to IGNORE.
- ACK states:
  - sda_oe=1 from the SCL fall after the 8th bit until the SCL fall after the 9th bit, then release.
  - ACK_ADDR -> SUB; ACK_SUB -> DATA; ACK_DATA -> IGNORE.
- SUB byte: latch reg[6:0]=byte[7:1] and data[8]=byte[0]. Always ACKed.
- DATA byte: always ACKed. At the SCL fall ending ACK_DATA, commit the frame:
  - wr_valid pulses 1 cycle; wr_addr/wr_data update the same cycle.
  - frame_count increments.
  - If addr == RESET_REG, all shadow registers are cleared.
  - Else if addr < NUM_REGS, shadow[addr] is written.
  - Else the shadow file is unchanged, but wr_valid still pulses.
- IGNORE: sda_oe=0, all further bits are NACKed, and the block waits for START or STOP.
- SCL held high with no edges: state holds indefinitely; there is no timeout.
- rd_data is a combinational read of the shadow file. A same-cycle write is visible one cycle later.
- Reset mid-frame: immediate return to reset values; sda_oe releases asynchronously.

Test Plan:
- START, 0x34, 0x04, 0x74, STOP -> 3 ACKs (SDA low during each 9th clock); one wr_valid with wr_addr=0x02, wr_data=0x074; rd_addr=2 gives 0x074; frame_count=1.
- Full 9-frame codec config sequence (regs 0F,06,08,02,03,07,09,04,05 with data 0,0,2,74,74,1,1,16,06) -> 9 wr_valid pulses; shadow[8]=0x002, shadow[5]=0x006; frame_count=9.
- Write reg 0x04=0x16, then reg 0x0F=0x000 -> all 16 shadow registers read 0 after the second pulse.
- Address 0x36 (0x1B) or 0x35 (read bit set) -> NACK on the 9th clock; no further ACKs; no wr_valid; busy drops at STOP.
- Abort cases:
  - STOP after the SUB byte -> no wr_valid; shadow unchanged.
  - Repeated START mid-DATA then a full valid frame -> exactly one wr_valid, carrying the second frame's values.
- 4th byte after a valid frame -> NACKed, exactly one wr_valid. Also assert reset during ACK_SUB -> sda_oe=0 immediately, outputs at reset values.
